// File: rtl/mux4bit_arbiter.sv
// Two-requester arbiter for a shared 2:1 mux. It drives the mux select and captures
// the mux output into a one-entry output register with valid/ready backpressure.
module mux4bit_arbiter_cnt #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Saturating increment: the counter sticks at all-ones instead of wrapping.
  always_comb begin
    cnt_d = cnt_q;
    if (inc && (cnt_q != '1)) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;
endmodule

module mux4bit_arbiter #(
  parameter int WIDTH = 4,
  parameter int RR    = 1,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             a_valid,
  output logic             a_ready,
  input  logic             b_valid,
  output logic             b_ready,
  output logic             mux_sel,
  input  logic [WIDTH-1:0] mux_o,
  output logic [WIDTH-1:0] out_data,
  output logic             out_src,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] cnt_a,
  output logic [CNT_W-1:0] cnt_b
);
  localparam bit USE_RR = (RR != 0);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             out_src_q, out_src_d;
  logic             last_q, last_d;

  logic             any_req, win_b, can_load, grant;
  logic [1:0]       inc;
  logic [1:0][CNT_W-1:0] cnt_all;

  assign any_req  = a_valid || b_valid;
  // last uses 0 = A, 1 = B; on a tie under round-robin the side that was not last wins.
  assign win_b    = b_valid && (!a_valid || (USE_RR && !last_q));
  assign can_load = (state_q == EMPTY) || out_ready;
  assign grant    = rst_n && can_load && any_req;

  assign a_ready  = grant && !win_b;
  assign b_ready  = grant &&  win_b;
  assign mux_sel  = any_req ? win_b : last_q;
  assign inc      = {b_ready, a_ready};

  always_comb begin
    state_d    = state_q;
    out_data_d = out_data_q;
    out_src_d  = out_src_q;
    last_d     = last_q;
    case (state_q)
      EMPTY: if (grant) state_d = FULL;
      FULL:  if (out_ready && !grant) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase
    if (grant) begin
      out_data_d = mux_o;
      out_src_d  = win_b;
      last_d     = win_b;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= EMPTY;
      out_data_q <= '0;
      out_src_q  <= 1'b0;
      last_q     <= 1'b1;
    end else begin
      state_q    <= state_d;
      out_data_q <= out_data_d;
      out_src_q  <= out_src_d;
      last_q     <= last_d;
    end
  end

  for (genvar g = 0; g < 2; g++) begin : g_cnt
    mux4bit_arbiter_cnt #(.CNT_W(CNT_W)) u_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (inc[g]),
      .cnt   (cnt_all[g])
    );
  end

  assign out_valid = (state_q == FULL);
  assign out_data  = out_data_q;
  assign out_src   = out_src_q;
  assign cnt_a     = cnt_all[0];
  assign cnt_b     = cnt_all[1];
endmodule

// File: tb/tb_mux4bit_arbiter.sv
// Directed bench: round-robin main instance plus fixed-priority and 2-bit-counter
// instances sharing the same requester stimulus; the main output stream goes through a scoreboard.
module tb_mux4bit_arbiter;
  logic clk = 1'b0;
  logic rst_n, a_valid, b_valid, out_ready;
  logic [3:0] a_dat, b_dat;

  logic       m_a_ready, m_b_ready, m_sel, m_out_src, m_out_valid;
  logic [3:0] m_mux_o, m_out_data;
  logic [7:0] m_cnt_a, m_cnt_b;

  logic       f_a_ready, f_b_ready, f_sel, f_out_src, f_out_valid;
  logic [3:0] f_mux_o, f_out_data;
  logic [7:0] f_cnt_a, f_cnt_b;

  logic       s_a_ready, s_b_ready, s_sel, s_out_src, s_out_valid;
  logic [3:0] s_mux_o, s_out_data;
  logic [1:0] s_cnt_a, s_cnt_b;

  int n_cmp = 0;
  int n_err = 0;
  logic [4:0] sb[$];

  always #5 clk = ~clk;

  assign m_mux_o = m_sel ? b_dat : a_dat;
  assign f_mux_o = f_sel ? b_dat : a_dat;
  assign s_mux_o = s_sel ? b_dat : a_dat;

  mux4bit_arbiter #(.WIDTH(4), .RR(1), .CNT_W(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .a_valid(a_valid), .a_ready(m_a_ready),
    .b_valid(b_valid), .b_ready(m_b_ready), .mux_sel(m_sel), .mux_o(m_mux_o),
    .out_data(m_out_data), .out_src(m_out_src), .out_valid(m_out_valid),
    .out_ready(out_ready), .cnt_a(m_cnt_a), .cnt_b(m_cnt_b));

  mux4bit_arbiter #(.WIDTH(4), .RR(0), .CNT_W(8)) u_fp (
    .clk(clk), .rst_n(rst_n), .a_valid(a_valid), .a_ready(f_a_ready),
    .b_valid(b_valid), .b_ready(f_b_ready), .mux_sel(f_sel), .mux_o(f_mux_o),
    .out_data(f_out_data), .out_src(f_out_src), .out_valid(f_out_valid),
    .out_ready(out_ready), .cnt_a(f_cnt_a), .cnt_b(f_cnt_b));

  mux4bit_arbiter #(.WIDTH(4), .RR(1), .CNT_W(2)) u_sat (
    .clk(clk), .rst_n(rst_n), .a_valid(a_valid), .a_ready(s_a_ready),
    .b_valid(b_valid), .b_ready(s_b_ready), .mux_sel(s_sel), .mux_o(s_mux_o),
    .out_data(s_out_data), .out_src(s_out_src), .out_valid(s_out_valid),
    .out_ready(out_ready), .cnt_a(s_cnt_a), .cnt_b(s_cnt_b));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; a_valid = 1'b0; b_valid = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  // Output transfers happen at the next rising edge; sample on the falling edge.
  always @(negedge clk) begin
    if (rst_n && m_out_valid && out_ready) begin
      chk("sb_nonempty", (sb.size() != 0), 1);
      if (sb.size() != 0) chk("sb_out", {m_out_src, m_out_data}, sb.pop_front());
    end
  end

  initial begin
    #50000;
    $display("FAIL timeout: simulation did not reach the end");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; a_valid = 1'b0; b_valid = 1'b0; out_ready = 1'b0;
    a_dat = '0; b_dat = '0;
    tick(); tick();
    chk("rst_out_valid", m_out_valid, 0);
    chk("rst_out_data", m_out_data, 0);
    chk("rst_out_src", m_out_src, 0);
    chk("rst_cnt_a", m_cnt_a, 0);
    chk("rst_cnt_b", m_cnt_b, 0);
    a_valid = 1'b1; b_valid = 1'b1; #1;
    chk("rst_a_ready", m_a_ready, 0);
    chk("rst_b_ready", m_b_ready, 0);
    a_valid = 1'b0; b_valid = 1'b0;
    rst_n = 1'b1;

    // A only
    a_valid = 1'b1; a_dat = 4'd5; b_dat = 4'd9; out_ready = 1'b1; #1;
    chk("t1_a_ready", m_a_ready, 1);
    chk("t1_b_ready", m_b_ready, 0);
    chk("t1_mux_sel", m_sel, 0);
    sb.push_back({1'b0, 4'd5});
    tick();
    a_valid = 1'b0;
    chk("t1_out_data", m_out_data, 5);
    chk("t1_out_src", m_out_src, 0);
    chk("t1_out_valid", m_out_valid, 1);
    chk("t1_cnt_a", m_cnt_a, 1);
    tick();
    chk("t1_drained", m_out_valid, 0);

    // Contention: round-robin alternates, fixed priority always picks A
    do_reset();
    a_valid = 1'b1; b_valid = 1'b1; a_dat = 4'd3; b_dat = 4'd12;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("t2_a_ready", m_a_ready, (k % 2 == 0));
      chk("t2_b_ready", m_b_ready, (k % 2 == 1));
      chk("t3_fp_a_ready", f_a_ready, 1);
      chk("t3_fp_b_ready", f_b_ready, 0);
      sb.push_back((k % 2 == 1) ? {1'b1, 4'd12} : {1'b0, 4'd3});
      tick();
      chk("t2_no_bubble", m_out_valid, 1);
    end
    a_valid = 1'b0; b_valid = 1'b0;
    chk("t2_cnt_a", m_cnt_a, 2);
    chk("t2_cnt_b", m_cnt_b, 2);
    chk("t3_fp_cnt_a", f_cnt_a, 4);
    chk("t3_fp_cnt_b", f_cnt_b, 0);
    tick(); tick();

    // Backpressure
    do_reset();
    a_valid = 1'b1; a_dat = 4'd7; out_ready = 1'b0;
    sb.push_back({1'b0, 4'd7});
    tick();
    b_valid = 1'b1; a_dat = 4'd1; b_dat = 4'd2;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("t4_stall_a_ready", m_a_ready, 0);
      chk("t4_stall_b_ready", m_b_ready, 0);
      chk("t4_hold_data", m_out_data, 7);
      chk("t4_hold_valid", m_out_valid, 1);
      tick();
    end
    out_ready = 1'b1; #1;
    chk("t4_rel_b_ready", m_b_ready, 1);
    chk("t4_rel_a_ready", m_a_ready, 0);
    chk("t4_rel_mux_sel", m_sel, 1);
    sb.push_back({1'b1, 4'd2});
    tick();
    a_valid = 1'b0; b_valid = 1'b0;
    chk("t4_reload_data", m_out_data, 2);
    chk("t4_reload_src", m_out_src, 1);
    chk("t4_cnt_a", m_cnt_a, 1);
    chk("t4_cnt_b", m_cnt_b, 1);
    tick();

    // Counter saturation on the 2-bit instance
    do_reset();
    a_valid = 1'b1; out_ready = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      a_dat = 4'(k);
      sb.push_back({1'b0, 4'(k)});
      tick();
      chk("t5_sat_cnt_a", s_cnt_a, (k > 3) ? 3 : k);
      chk("t5_main_cnt_a", m_cnt_a, k);
    end
    a_valid = 1'b0;
    tick(); tick();

    // Reset while holding a stalled word
    a_valid = 1'b1; a_dat = 4'd6; out_ready = 1'b0;
    tick();
    a_valid = 1'b0;
    chk("t6_pre_valid", m_out_valid, 1);
    rst_n = 1'b0;
    tick();
    chk("t6_rst_valid", m_out_valid, 0);
    chk("t6_rst_cnt_a", m_cnt_a, 0);
    chk("t6_rst_cnt_b", m_cnt_b, 0);
    chk("t6_rst_data", m_out_data, 0);
    rst_n = 1'b1;
    a_valid = 1'b1; b_valid = 1'b1; a_dat = 4'd10; b_dat = 4'd11; out_ready = 1'b1; #1;
    chk("t6_tie_a_ready", m_a_ready, 1);
    chk("t6_tie_b_ready", m_b_ready, 0);
    chk("t6_tie_mux_sel", m_sel, 0);
    sb.push_back({1'b0, 4'd10});
    tick();
    a_valid = 1'b0; b_valid = 1'b0;
    tick(); tick();

    chk("sb_leftover", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
